// File: rtl/fila_pkg.sv
// ============================================================================
// fila_pkg : shared FSM state type and default sizes for fila_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

package fila_pkg;

   localparam int DEPTH_DEFAULT = 8;
   localparam int W_DEFAULT     = 8;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      ISSUE_ENQ = 3'd1,
      ISSUE_DEQ = 3'd2,
      WAIT      = 3'd3,
      DONE_DEQ  = 3'd4
   } fila_state_e;

endpackage

`default_nettype wire

// File: rtl/fila_arbiter_rr_arb2.sv
// ============================================================================
// rr_arb2 : two-way round-robin arbiter, requester 0 favoured after reset
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // ptr == 0 means requester 0 wins a tie, ptr == 1 means requester 1 wins
   logic ptr;

   always_comb begin
      gnt = 2'b00;
      if (req[0] && (!ptr || !req[1])) begin
         gnt = 2'b01;
      end else if (req[1]) begin
         gnt = 2'b10;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (advance && (gnt != 2'b00)) begin
         ptr <= gnt[0];
      end
   end

endmodule

`default_nettype wire

// File: rtl/fila_arbiter.sv
// ============================================================================
// fila_arbiter : arbitrates two producers and one consumer onto a single queue
// Optional grant/dequeue counters when FILA_ARBITER_STATS_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fila_arbiter
   import fila_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEFAULT,
   parameter int W     = W_DEFAULT
) (
   input  logic         clock_10khz,
   input  logic         reset,
   input  logic         req_a_in,
   input  logic [W-1:0] data_a_in,
   output logic         gnt_a_out,
   input  logic         req_b_in,
   input  logic [W-1:0] data_b_in,
   output logic         gnt_b_out,
   input  logic         deq_req_in,
   output logic         deq_valid_out,
   output logic [W-1:0] deq_data_out,
   output logic         fila_enqueue_out,
   output logic         fila_dequeue_out,
   output logic [W-1:0] fila_data_out,
   input  logic [7:0]   fila_len_in,
   input  logic [W-1:0] fila_data_in,
   output logic         full_out,
   output logic         empty_out
`ifdef FILA_ARBITER_STATS_EN
   ,
   output logic [7:0]   cnt_a_out,
   output logic [7:0]   cnt_b_out,
   output logic [7:0]   cnt_deq_out
`endif
);

   fila_state_e state;
   logic        last_was_enq;
   logic        enq_ok;
   logic        deq_ok;
   logic        pick_enq;
   logic        pick_deq;
   logic        rr_adv;
   logic [1:0]  rr_gnt;

   always_comb begin
      full_out  = (fila_len_in == 8'(DEPTH));
      empty_out = (fila_len_in == 8'd0);
      enq_ok    = (req_a_in | req_b_in) & ~full_out;
      deq_ok    = deq_req_in & ~empty_out;
      // on a tie the op type opposite to the previous one wins
      pick_deq  = deq_ok & (~enq_ok | last_was_enq);
      pick_enq  = enq_ok & ~pick_deq;
      rr_adv    = (state == IDLE) & pick_enq;
   end

   rr_arb2 u_rr (
      .clk     (clock_10khz),
      .rst     (reset),
      .req     ({req_b_in, req_a_in}),
      .advance (rr_adv),
      .gnt     (rr_gnt)
   );

   always_ff @(posedge clock_10khz or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         last_was_enq     <= 1'b1;
         gnt_a_out        <= 1'b0;
         gnt_b_out        <= 1'b0;
         fila_enqueue_out <= 1'b0;
         fila_dequeue_out <= 1'b0;
         fila_data_out    <= '0;
         deq_valid_out    <= 1'b0;
         deq_data_out     <= '0;
      end else begin
         gnt_a_out        <= 1'b0;
         gnt_b_out        <= 1'b0;
         fila_enqueue_out <= 1'b0;
         fila_dequeue_out <= 1'b0;
         deq_valid_out    <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_deq) begin
                  state            <= ISSUE_DEQ;
                  fila_dequeue_out <= 1'b1;
                  last_was_enq     <= 1'b0;
               end else if (pick_enq) begin
                  state            <= ISSUE_ENQ;
                  fila_enqueue_out <= 1'b1;
                  gnt_a_out        <= rr_gnt[0];
                  gnt_b_out        <= rr_gnt[1];
                  fila_data_out    <= rr_gnt[1] ? data_b_in : data_a_in;
                  last_was_enq     <= 1'b1;
               end
            end
            ISSUE_ENQ, ISSUE_DEQ: state <= WAIT;
            // last_was_enq doubles as "operation in flight was an enqueue"
            WAIT:     state <= last_was_enq ? IDLE : DONE_DEQ;
            DONE_DEQ: begin
               deq_data_out  <= fila_data_in;
               deq_valid_out <= 1'b1;
               state         <= IDLE;
            end
            default:  state <= IDLE;
         endcase
      end
   end

`ifdef FILA_ARBITER_STATS_EN
   always_ff @(posedge clock_10khz or posedge reset) begin
      if (reset) begin
         cnt_a_out   <= 8'd0;
         cnt_b_out   <= 8'd0;
         cnt_deq_out <= 8'd0;
      end else begin
         if (gnt_a_out && (cnt_a_out != 8'hFF)) cnt_a_out <= cnt_a_out + 8'd1;
         if (gnt_b_out && (cnt_b_out != 8'hFF)) cnt_b_out <= cnt_b_out + 8'd1;
         if (fila_dequeue_out && (cnt_deq_out != 8'hFF)) cnt_deq_out <= cnt_deq_out + 8'd1;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fila_arbiter.sv
// ============================================================================
// tb_fila_arbiter : directed, table-driven checks of fila_arbiter
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fila_arbiter;

   localparam int DEPTH = 8;
   localparam int W     = 8;

   logic         clock_10khz = 1'b0;
   logic         reset       = 1'b1;
   logic         req_a_in    = 1'b0;
   logic [W-1:0] data_a_in   = '0;
   logic         gnt_a_out;
   logic         req_b_in    = 1'b0;
   logic [W-1:0] data_b_in   = '0;
   logic         gnt_b_out;
   logic         deq_req_in  = 1'b0;
   logic         deq_valid_out;
   logic [W-1:0] deq_data_out;
   logic         fila_enqueue_out;
   logic         fila_dequeue_out;
   logic [W-1:0] fila_data_out;
   logic [7:0]   fila_len_in  = 8'd0;
   logic [W-1:0] fila_data_in = '0;
   logic         full_out;
   logic         empty_out;
`ifdef FILA_ARBITER_STATS_EN
   logic [7:0]   cnt_a_out, cnt_b_out, cnt_deq_out;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   fila_arbiter #(.DEPTH(DEPTH), .W(W)) dut (
      .clock_10khz      (clock_10khz),
      .reset            (reset),
      .req_a_in         (req_a_in),
      .data_a_in        (data_a_in),
      .gnt_a_out        (gnt_a_out),
      .req_b_in         (req_b_in),
      .data_b_in        (data_b_in),
      .gnt_b_out        (gnt_b_out),
      .deq_req_in       (deq_req_in),
      .deq_valid_out    (deq_valid_out),
      .deq_data_out     (deq_data_out),
      .fila_enqueue_out (fila_enqueue_out),
      .fila_dequeue_out (fila_dequeue_out),
      .fila_data_out    (fila_data_out),
      .fila_len_in      (fila_len_in),
      .fila_data_in     (fila_data_in),
      .full_out         (full_out),
      .empty_out        (empty_out)
`ifdef FILA_ARBITER_STATS_EN
      ,
      .cnt_a_out        (cnt_a_out),
      .cnt_b_out        (cnt_b_out),
      .cnt_deq_out      (cnt_deq_out)
`endif
   );

   always #5 clock_10khz = ~clock_10khz;

   typedef struct {
      logic [7:0] len;
      logic       a, b, d;
      logic [7:0] da, db;
      logic       x_full, x_empty, x_enq, x_deq, x_ga, x_gb;
      logic [7:0] x_fdata;
   } vec_t;

   vec_t vt[10];

   function automatic vec_t mk(input logic [7:0] len, input logic a, b, d,
                               input logic [7:0] da, db,
                               input logic xf, xe, xenq, xdeq, xga, xgb,
                               input logic [7:0] xfd);
      vec_t v;
      v.len = len; v.a = a; v.b = b; v.d = d; v.da = da; v.db = db;
      v.x_full = xf; v.x_empty = xe; v.x_enq = xenq; v.x_deq = xdeq;
      v.x_ga = xga; v.x_gb = xgb; v.x_fdata = xfd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock_10khz);
      #1;
   endtask

   task automatic clear_inputs();
      req_a_in = 1'b0; req_b_in = 1'b0; deq_req_in = 1'b0;
      data_a_in = '0; data_b_in = '0; fila_len_in = 8'd0; fila_data_in = '0;
   endtask

   // leaves the bench 1 time unit after a rising edge with the DUT in IDLE
   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      vt[0] = mk(8'd0, 1, 0, 0, 8'h11, 8'h21, 0, 1, 1, 0, 1, 0, 8'h11);
      vt[1] = mk(8'd0, 0, 1, 0, 8'h12, 8'h22, 0, 1, 1, 0, 0, 1, 8'h22);
      vt[2] = mk(8'd0, 1, 1, 0, 8'h13, 8'h23, 0, 1, 1, 0, 1, 0, 8'h13);
      vt[3] = mk(8'd0, 0, 0, 1, 8'h14, 8'h24, 0, 1, 0, 0, 0, 0, 8'h00);
      vt[4] = mk(8'd3, 0, 0, 1, 8'h15, 8'h25, 0, 0, 0, 1, 0, 0, 8'h00);
      vt[5] = mk(8'd3, 1, 0, 1, 8'h16, 8'h26, 0, 0, 0, 1, 0, 0, 8'h00);
      vt[6] = mk(8'd8, 1, 0, 0, 8'h17, 8'h27, 1, 0, 0, 0, 0, 0, 8'h00);
      vt[7] = mk(8'd8, 1, 1, 1, 8'h18, 8'h28, 1, 0, 0, 1, 0, 0, 8'h00);
      vt[8] = mk(8'd7, 0, 1, 0, 8'h19, 8'h29, 0, 0, 1, 0, 0, 1, 8'h29);
      vt[9] = mk(8'd1, 0, 0, 0, 8'h1A, 8'h2A, 0, 0, 0, 0, 0, 0, 8'h00);

      // reset state while reset is held
      tick();
      chk("rst_gnt", {gnt_a_out, gnt_b_out}, 2'b00);
      chk("rst_cmd", {fila_enqueue_out, fila_dequeue_out, deq_valid_out}, 3'b000);
      chk("rst_fdata", fila_data_out, 8'h00);
      chk("rst_ddata", deq_data_out, 8'h00);

      // first decision out of IDLE for each vector, from a fresh reset
      for (int i = 0; i < 10; i++) begin
         do_reset();
         fila_len_in = vt[i].len;
         req_a_in = vt[i].a; req_b_in = vt[i].b; deq_req_in = vt[i].d;
         data_a_in = vt[i].da; data_b_in = vt[i].db;
         #1;
         chk($sformatf("v%0d_full", i), full_out, vt[i].x_full);
         chk($sformatf("v%0d_empty", i), empty_out, vt[i].x_empty);
         tick();
         chk($sformatf("v%0d_enq", i), fila_enqueue_out, vt[i].x_enq);
         chk($sformatf("v%0d_deq", i), fila_dequeue_out, vt[i].x_deq);
         chk($sformatf("v%0d_gnt", i), {gnt_a_out, gnt_b_out}, {vt[i].x_ga, vt[i].x_gb});
         chk($sformatf("v%0d_fdata", i), fila_data_out, vt[i].x_fdata);
         clear_inputs();
         repeat (5) tick();
      end

      // single producer held: grant in cycle 1, back in IDLE at cycle 3
      do_reset();
      req_a_in = 1'b1; data_a_in = 8'h11;
      for (int c = 1; c <= 4; c++) begin
         tick();
         chk($sformatf("a_only_c%0d_gnt", c), gnt_a_out, (c == 1 || c == 4));
         chk($sformatf("a_only_c%0d_enq", c), fila_enqueue_out, (c == 1 || c == 4));
         if (c == 1) chk("a_only_fdata", fila_data_out, 8'h11);
      end

      // both producers held: A,B,A,B at 3-cycle spacing
      do_reset();
      req_a_in = 1'b1; req_b_in = 1'b1; data_a_in = 8'hA1; data_b_in = 8'hB2;
      for (int c = 1; c <= 12; c++) begin
         logic ea, eb;
         tick();
         ea = (c == 1 || c == 7);
         eb = (c == 4 || c == 10);
         chk($sformatf("rr_c%0d", c), {gnt_a_out, gnt_b_out}, {ea, eb});
         if (ea) chk($sformatf("rr_c%0d_fdata", c), fila_data_out, 8'hA1);
         if (eb) chk($sformatf("rr_c%0d_fdata", c), fila_data_out, 8'hB2);
      end

      // dequeue latency and data hold
      do_reset();
      fila_len_in = 8'd1; fila_data_in = 8'h22; deq_req_in = 1'b1;
      tick(); chk("dq_c1_cmd", fila_dequeue_out, 1'b1);
      tick(); chk("dq_c2_valid", deq_valid_out, 1'b0);
      tick(); chk("dq_c3_valid", deq_valid_out, 1'b0);
      tick(); chk("dq_c4_valid", deq_valid_out, 1'b1);
      chk("dq_c4_data", deq_data_out, 8'h22);
      deq_req_in = 1'b0; fila_len_in = 8'd0; fila_data_in = 8'h00;
      tick(); chk("dq_c5_valid", deq_valid_out, 1'b0);
      chk("dq_c5_data", deq_data_out, 8'h22);

      // full queue: dequeue only, enqueue after occupancy drops
      do_reset();
      fila_len_in = 8'd8; req_a_in = 1'b1; deq_req_in = 1'b1; data_a_in = 8'h33;
      tick();
      chk("full_c1_deq", fila_dequeue_out, 1'b1);
      chk("full_c1_gnt", gnt_a_out, 1'b0);
      fila_len_in = 8'd7;
      tick(); chk("full_c2_gnt", gnt_a_out, 1'b0);
      tick(); chk("full_c3_gnt", gnt_a_out, 1'b0);
      tick(); chk("full_c4_valid", deq_valid_out, 1'b1);
      chk("full_c4_gnt", gnt_a_out, 1'b0);
      deq_req_in = 1'b0;
      tick();
      chk("full_c5_gnt", gnt_a_out, 1'b1);
      chk("full_c5_enq", fila_enqueue_out, 1'b1);
      chk("full_c5_fdata", fila_data_out, 8'h33);
      req_a_in = 1'b0;
      repeat (3) tick();

      // enqueue and dequeue both held: deq first, then alternate
      do_reset();
      fila_len_in = 8'd4; req_a_in = 1'b1; deq_req_in = 1'b1; data_a_in = 8'h44;
      for (int c = 1; c <= 15; c++) begin
         tick();
         chk($sformatf("alt_c%0d", c), {fila_enqueue_out, fila_dequeue_out},
             {(c == 5 || c == 12), (c == 1 || c == 8 || c == 15)});
      end

      // reset asserted during ISSUE_ENQ
      do_reset();
      req_a_in = 1'b1; data_a_in = 8'h55;
      tick();
      chk("mid_rst_pre_gnt", gnt_a_out, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_gnt", {gnt_a_out, gnt_b_out}, 2'b00);
      chk("mid_rst_enq", fila_enqueue_out, 1'b0);
      chk("mid_rst_fdata", fila_data_out, 8'h00);
      req_a_in = 1'b0;
      @(negedge clock_10khz);
      reset = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         tick();
         chk($sformatf("post_rst_c%0d", c), {gnt_a_out, fila_enqueue_out, fila_dequeue_out}, 3'b000);
      end
      req_b_in = 1'b1; data_b_in = 8'h66;
      tick();
      chk("post_rst_gnt_b", gnt_b_out, 1'b1);
      chk("post_rst_fdata", fila_data_out, 8'h66);
      req_b_in = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fila_arbiter.md
FILA_ARBITER -- requirements
Module: fila_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, meaning queue capacity in entries; fila_len_in == DEPTH means full.
REQ-002 Parameter W, default 8, meaning data width in bits.
REQ-003 clock_10khz  input  1  single system clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_a_in  input  1  producer A enqueue request, level, held until granted.
REQ-006 data_a_in  input  W  producer A data, stable while req_a_in high.
REQ-007 gnt_a_out  output  1  one-cycle pulse, A's data accepted.
REQ-008 req_b_in / data_b_in / gnt_b_out  same as A, for producer B.
REQ-009 deq_req_in  input  1  consumer dequeue request, level, held until deq_valid_out.
REQ-010 deq_valid_out  output  1  one-cycle pulse, deq_data_out valid.
REQ-011 deq_data_out  output  W  dequeued word, held until next dequeue.
REQ-012 fila_enqueue_out / fila_dequeue_out  output  1  one-cycle command pulses to the queue.
REQ-013 fila_data_out  output  W  registered enqueue data to the queue.
REQ-014 fila_len_in  input  8  queue occupancy.
REQ-015 fila_data_in  input  W  queue read data.
REQ-016 full_out / empty_out  output  1  combinational (fila_len_in == DEPTH) / (fila_len_in == 0).

Function
REQ-017 FSM states: IDLE, ISSUE_ENQ, ISSUE_DEQ, WAIT, DONE_DEQ; all other encodings SHALL go to IDLE.
REQ-018 IDLE: eligible enqueue = (req_a_in | req_b_in) & !full; eligible dequeue = deq_req_in & !empty.
REQ-019 Only enqueue eligible -> ISSUE_ENQ; only dequeue eligible -> ISSUE_DEQ; neither -> stay in IDLE.
REQ-020 Both eligible -> pick the op type opposite to the last one issued; after reset, dequeue goes first.
REQ-021 A vs B: two-way round-robin; after reset A has priority; after a grant to X, the other requester has priority.
REQ-022 On the IDLE->ISSUE_ENQ edge: latch the winner's data into fila_data_out and record the winner.
REQ-023 ISSUE_ENQ (exactly one cycle): fila_enqueue_out=1 and the winner's gnt pulse=1; then WAIT.
REQ-024 ISSUE_DEQ (exactly one cycle): fila_dequeue_out=1; then WAIT.
REQ-025 WAIT (exactly one cycle): no command, so the queue can return to idle; after a dequeue go to DONE_DEQ, else IDLE.
REQ-026 DONE_DEQ edge: deq_data_out <= fila_data_in; deq_valid_out=1 in the following IDLE cycle only.
REQ-027 Latency: request first seen in IDLE at cycle 0 -> command/grant in cycle 1; enqueue back in IDLE at cycle 3; dequeue valid in cycle 4.
REQ-028 Throughput: at most one queue operation per 3 cycles (enqueue) or 4 cycles (dequeue).
REQ-029 Requests arriving or dropping outside IDLE SHALL be ignored until the next IDLE.
REQ-030 Full: no enqueue grant, dequeue still served; empty: no dequeue, enqueue still served.
REQ-031 Never assert fila_enqueue_out and fila_dequeue_out in the same cycle.

Reset
REQ-032 Reset (asynchronous, any state, mid-operation included) -> state IDLE, all outputs 0, deq_data_out 0, fila_data_out 0.
REQ-033 Reset -> round-robin pointer to A, last-op flag to "enqueue" (so dequeue wins first).
REQ-034 The controller and the queue SHALL share reset; no command pulse SHALL be truncated into a partial operation after reset release.

Configuration
REQ-035 Macro FILA_ARBITER_STATS_EN defined: add outputs cnt_a_out, cnt_b_out, cnt_deq_out (8 bit each) counting grants/dequeues, saturating at 255, cleared by reset.
REQ-036 Macro FILA_ARBITER_STATS_EN not defined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-037 Package fila_pkg SHALL hold the FSM state enum, the DEPTH default constant and the W default constant.
REQ-038 Sub-module rr_arb2 (two-way round-robin arbiter: req[1:0], advance, gnt[1:0], pointer register) SHALL be instantiated once.

Verification
REQ-039 Reset, req_a_in=1 with data_a_in=0x11 -> gnt_a_out and fila_enqueue_out in cycle 1, fila_data_out=0x11, back in IDLE at cycle 3.
REQ-040 req_a_in and req_b_in held together with queue not full -> grants alternate A,B,A,B at 3-cycle spacing.
REQ-041 Queue holds 0x22; deq_req_in=1 -> fila_dequeue_out in cycle 1, deq_valid_out in cycle 4 with deq_data_out=0x22.
REQ-042 fila_len_in=8, req_a_in=1 and deq_req_in=1 -> dequeue only, no gnt_a_out; enqueue granted after len drops to 7.
REQ-043 Enqueue and dequeue held together -> first op after reset is a dequeue, then the two op types alternate.
REQ-044 Reset pulsed during ISSUE_ENQ -> all outputs 0 immediately, IDLE after release, no gnt pulse.
